// File: rtl/bc_id_hazard_ctrl_pkg.sv
// Shared types for the BureCore decode-stage issue controller.
package BC_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {ST_RUN, ST_FLUSH} flush_state_e;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/bc_id_hazard_ctrl_pending_table.sv
// Per-register pending bits for in-flight destinations, with optional write-back
// bypass applied to the three decode lookups.
module bc_pending_table
  import BC_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  input  logic      set_en_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t rs1_addr_i,
  input  reg_addr_t rs2_addr_i,
  input  reg_addr_t rd_addr_i,
  output logic      rs1_pend_o,
  output logic      rs2_pend_o,
  output logic      rd_pend_o,
  output logic      clr_hit_o
);

  localparam logic BYP = (WB_BYPASS != 0);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  function automatic logic pend_eff(input logic [NUM_REGS-1:0] p, input reg_addr_t a,
                                    input logic clr_en, input reg_addr_t clr_addr);
    return p[a] & (a != 5'd0) & ~(BYP & clr_en & (clr_addr == a));
  endfunction

  assign rs1_pend_o = pend_eff(pending_q, rs1_addr_i, clr_en_i, clr_addr_i);
  assign rs2_pend_o = pend_eff(pending_q, rs2_addr_i, clr_en_i, clr_addr_i);
  assign rd_pend_o  = pend_eff(pending_q, rd_addr_i, clr_en_i, clr_addr_i);
  assign clr_hit_o  = pending_q[clr_addr_i] & (clr_addr_i != 5'd0);

  // Set is applied after clear so a same-register issue/retire keeps the entry.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (set_en_i) begin
      pending_d[set_addr_i] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/bc_id_hazard_ctrl.sv
// Decode issue controller: scoreboard-based RAW/WAW and window stalls, plus a
// flush FSM that squashes wrong-path fetches after a taken branch.
module bc_id_hazard_ctrl
  import BC_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int WB_BYPASS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1_addr,
  input  logic       i_id_rs1_used,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_rs2_used,
  input  logic       i_id_rd_wen,
  input  logic [4:0] i_id_rd_addr,
  input  logic       i_branch_taken,
  input  logic       i_wb_valid,
  input  logic [4:0] i_wb_addr,
  output logic       o_id_stall,
  output logic       o_id_issue,
  output logic       o_if_flush,
  output logic [3:0] o_inflight,
  output logic       o_wb_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);
  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic       BYP     = (WB_BYPASS != 0);

  flush_state_e state_q;
  logic [2:0]   cnt_q;
  logic         flush_q;
  logic [3:0]   inflight_q;
  logic [3:0]   inflight_d;
  logic         wb_err_q;

  logic rs1_pend, rs2_pend, rd_pend, wb_hit;
  logic wb_retire, win_full, hazard, in_run, track;

  bc_pending_table #(
    .NUM_REGS (NUM_REGS),
    .WB_BYPASS(WB_BYPASS)
  ) u_pend (
    .clk_i     (i_clk),
    .rstn_i    (i_rstn),
    .set_en_i  (track),
    .set_addr_i(i_id_rd_addr),
    .clr_en_i  (i_wb_valid),
    .clr_addr_i(i_wb_addr),
    .rs1_addr_i(i_id_rs1_addr),
    .rs2_addr_i(i_id_rs2_addr),
    .rd_addr_i (i_id_rd_addr),
    .rs1_pend_o(rs1_pend),
    .rs2_pend_o(rs2_pend),
    .rd_pend_o (rd_pend),
    .clr_hit_o (wb_hit)
  );

  assign wb_retire = i_wb_valid & wb_hit;
  // A retiring entry frees a window slot in the same cycle only when bypassed.
  assign win_full  = i_id_rd_wen & (i_id_rd_addr != 5'd0) & (inflight_q == MAX_CNT)
                   & ~(BYP & wb_retire);
  assign hazard    = (i_id_rs1_used & rs1_pend) | (i_id_rs2_used & rs2_pend)
                   | (i_id_rd_wen & rd_pend) | win_full;
  assign in_run    = (state_q == ST_RUN);
  assign o_id_stall = i_rstn & i_id_valid & hazard & in_run;
  assign o_id_issue = i_rstn & i_id_valid & ~hazard & in_run;
  assign track      = o_id_issue & i_id_rd_wen & (i_id_rd_addr != 5'd0);

  assign o_if_flush = flush_q;
  assign o_inflight = inflight_q;
  assign o_wb_err   = wb_err_q;

  always_comb begin
    inflight_d = inflight_q;
    case ({track, wb_retire})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      inflight_q <= 4'd0;
      wb_err_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      wb_err_q   <= i_wb_valid & ~wb_hit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (o_id_issue & i_branch_taken) begin
            state_q <= ST_FLUSH;
            cnt_q   <= FL_INIT;
            flush_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 3'd0) begin
            state_q <= ST_RUN;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= 3'd0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bc_id_hazard_ctrl.sv
// Directed-vector bench for bc_id_hazard_ctrl (bypassed instance plus a non-bypassed one).
module tb_bc_id_hazard_ctrl;

  typedef struct {
    logic       rstn, valid;
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u, rdw;
    logic [4:0] rd;
    logic       br, wbv;
    logic [4:0] wba;
    logic       e_stall, e_issue, e_flush;
    logic [3:0] e_inf;
    logic       e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rstn, valid, rs1u, rs2u, rdw, br, wbv;
  logic [4:0] rs1, rs2, rd, wba;
  logic stall_a, issue_a, flush_a, err_a;
  logic stall_b, issue_b, flush_b, err_b;
  logic [3:0] inf_a, inf_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bc_id_hazard_ctrl #(.WB_BYPASS(1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_id_valid(valid),
    .i_id_rs1_addr(rs1), .i_id_rs1_used(rs1u), .i_id_rs2_addr(rs2), .i_id_rs2_used(rs2u),
    .i_id_rd_wen(rdw), .i_id_rd_addr(rd), .i_branch_taken(br),
    .i_wb_valid(wbv), .i_wb_addr(wba),
    .o_id_stall(stall_a), .o_id_issue(issue_a), .o_if_flush(flush_a),
    .o_inflight(inf_a), .o_wb_err(err_a)
  );

  bc_id_hazard_ctrl #(.WB_BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rstn(rstn), .i_id_valid(valid),
    .i_id_rs1_addr(rs1), .i_id_rs1_used(rs1u), .i_id_rs2_addr(rs2), .i_id_rs2_used(rs2u),
    .i_id_rd_wen(rdw), .i_id_rd_addr(rd), .i_branch_taken(br),
    .i_wb_valid(wbv), .i_wb_addr(wba),
    .o_id_stall(stall_b), .o_id_issue(issue_b), .o_if_flush(flush_b),
    .o_inflight(inf_b), .o_wb_err(err_b)
  );

  function automatic vec_t mk(input int r, va, a1, u1, a2, u2, w, d, b, wv, wa,
                              input int es, ei, ef, en, ee);
    vec_t v;
    v.rstn = 1'(r);   v.valid = 1'(va);
    v.rs1 = 5'(a1);   v.rs1u = 1'(u1);
    v.rs2 = 5'(a2);   v.rs2u = 1'(u2);
    v.rdw = 1'(w);    v.rd = 5'(d);
    v.br = 1'(b);     v.wbv = 1'(wv);   v.wba = 5'(wa);
    v.e_stall = 1'(es); v.e_issue = 1'(ei); v.e_flush = 1'(ef);
    v.e_inf = 4'(en); v.e_err = 1'(ee);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Drive one vector, check the combinational outputs, then the registered ones after the edge.
  task automatic apply(input vec_t v, input int idx, input bit sel_nb);
    rstn = v.rstn; valid = v.valid; rs1 = v.rs1; rs1u = v.rs1u; rs2 = v.rs2; rs2u = v.rs2u;
    rdw = v.rdw; rd = v.rd; br = v.br; wbv = v.wbv; wba = v.wba;
    #1;
    chk(sel_nb ? "nb_stall" : "stall", idx, 4'(sel_nb ? stall_b : stall_a), 4'(v.e_stall));
    chk(sel_nb ? "nb_issue" : "issue", idx, 4'(sel_nb ? issue_b : issue_a), 4'(v.e_issue));
    @(posedge clk);
    #1;
    chk(sel_nb ? "nb_flush" : "flush", idx, 4'(sel_nb ? flush_b : flush_a), 4'(v.e_flush));
    chk(sel_nb ? "nb_inflight" : "inflight", idx, sel_nb ? inf_b : inf_a, v.e_inf);
    chk(sel_nb ? "nb_wb_err" : "wb_err", idx, 4'(sel_nb ? err_b : err_a), 4'(v.e_err));
  endtask

  vec_t vecs[$];
  vec_t nbv[$];

  initial begin
    rstn = 1'b0; valid = 1'b0; rs1 = 5'd0; rs1u = 1'b0; rs2 = 5'd0; rs2u = 1'b0;
    rdw = 1'b0; rd = 5'd0; br = 1'b0; wbv = 1'b0; wba = 5'd0;

    //             r va a1 u1 a2 u2 w  d  b wv wa   st is fl inf err
    vecs.push_back(mk(0,1, 0,0, 0,0, 1, 5, 0,0, 0,  0,0,0,0,0));  // reset
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 5, 0,0, 0,  0,1,0,1,0));  // RAW
    vecs.push_back(mk(1,1, 5,1, 0,0, 0, 0, 0,0, 0,  1,0,0,1,0));
    vecs.push_back(mk(1,1, 5,1, 0,0, 0, 0, 0,1, 5,  0,1,0,0,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 0, 0,0, 0,  0,1,0,0,0));  // x0
    vecs.push_back(mk(1,1, 0,1, 0,0, 0, 0, 0,0, 0,  0,1,0,0,0));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0, 0,1, 0,  0,0,0,0,1));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0, 0,0, 0,  0,0,0,0,0));
    for (int k = 1; k <= 4; k++)                                  // window
      vecs.push_back(mk(1,1, 0,0, 0,0, 1, k, 0,0, 0,  0,1,0,k,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 6, 0,0, 0,  1,0,0,4,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 0, 0,0, 0,  0,1,0,4,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 6, 0,1, 2,  0,1,0,4,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 7, 0,1, 2,  1,0,0,4,1));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0, 0,1, 1,  0,0,0,3,0));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0, 0,1, 4,  0,0,0,2,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 7, 0,1, 3,  0,1,0,2,0));  // simultaneous
    vecs.push_back(mk(1,1, 7,1, 3,1, 0, 0, 0,0, 0,  1,0,0,2,0));
    vecs.push_back(mk(1,1, 0,0, 3,1, 0, 0, 0,0, 0,  0,1,0,2,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 6, 0,0, 0,  1,0,0,2,0));  // WAW
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 7, 0,1, 7,  0,1,0,2,0));  // set wins
    vecs.push_back(mk(1,1, 7,1, 0,0, 0, 0, 0,0, 0,  1,0,0,2,0));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0, 0,1, 6,  0,0,0,1,0));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0, 0,1, 7,  0,0,0,0,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 8, 1,0, 0,  0,1,1,1,0));  // branch
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 9, 1,1, 8,  0,0,1,0,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 0, 0, 1,0, 0,  0,0,0,0,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1, 9, 0,0, 0,  0,1,0,1,0));
    vecs.push_back(mk(1,1, 0,0, 0,0, 1,10, 0,0, 0,  0,1,0,2,0));
    vecs.push_back(mk(1,1,10,1, 0,0, 0, 0, 1,0, 0,  1,0,0,2,0));  // stalled branch
    vecs.push_back(mk(1,1, 0,0, 0,0, 1,11, 1,0, 0,  0,1,1,3,0));
    vecs.push_back(mk(0,1,10,1, 0,0, 1,12, 1,0, 0,  0,0,0,0,0));  // reset in FLUSH
    vecs.push_back(mk(1,1,10,1, 0,0, 0, 0, 0,0, 0,  0,1,0,0,0));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0, 0,1,10,  0,0,0,0,1));

    nbv.push_back(mk(0,0, 0,0, 0,0, 0, 0, 0,0, 0,  0,0,0,0,0));
    nbv.push_back(mk(1,1, 0,0, 0,0, 1, 5, 0,0, 0,  0,1,0,1,0));
    nbv.push_back(mk(1,1, 5,1, 0,0, 0, 0, 0,1, 5,  1,0,0,0,0));
    nbv.push_back(mk(1,1, 5,1, 0,0, 0, 0, 0,0, 0,  0,1,0,0,0));

    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i, 1'b0);
    for (int i = 0; i < nbv.size(); i++) apply(nbv[i], 100 + i, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
